ysyx_22040729_wb_arbiter: RTL

//  Writeback-side driver of the integer register file write port. Merges single-cycle
//  ALU results and variable-latency LSU load results into one registered write
//  (rf_wen/rf_waddr/rf_wdata). A small load queue absorbs ALU/LSU collisions.
//  A per-register pending scoreboard flags in-flight destinations to decode (busy1/busy2).

---
 rtl/ysyx_22040729_wb_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040729_wb_arbiter.sv
// Generic circular FIFO used as the writeback load queue.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full comes from the registered count; pushes while full are dropped.
module ysyx_22040729_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_vld,
   output logic             head_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (cnt_q == CW'(DEPTH));
   assign head_vld = (cnt_q != '0);
   assign head_dat = mem_q[rd_ptr_q];
   assign do_push  = push_vld && !full;
   assign do_pop   = pop_vld && head_vld;

   // Next pointers and occupancy; simultaneous push and pop keeps the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage array; contents are meaningless while the count is zero, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   // Pointer and count registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// Writeback arbiter: merges ALU and LSU results into one registered RF write port.
// Latency: 1 cycle from selection to rf_*; busy reflects the registered scoreboard.
// Backpressure: ALU never stalls; LSU is held off when the load queue is full.
module ysyx_22040729_wb_arbiter #(
   parameter int REGI_DEPTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int LQ_DEPTH   = 2,
   localparam int AW        = $clog2(REGI_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [AW-1:0]         alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [AW-1:0]         lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   input  logic [AW-1:0]         raddr1,
   input  logic [AW-1:0]         raddr2,
   output logic                  busy1,
   output logic                  busy2,
   output logic                  rf_wen,
   output logic [AW-1:0]         rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   typedef struct packed {
      logic [AW-1:0]         rd;
      logic [DATA_WIDTH-1:0] data;
   } ld_t;

   ld_t                   lq_push_dat, lq_head_dat;
   logic                  lq_push_vld, lq_pop_vld, lq_head_vld, lq_full;
   logic                  lsu_acc;

   logic                  sel_vld;
   logic [AW-1:0]         sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  rf_wen_q, rf_wen_d;
   logic [AW-1:0]         rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic [REGI_DEPTH-1:0] pend_q, pend_d;

   // Ready is derived from the registered occupancy only, and is held low in reset.
   assign lsu_ready   = rst && !lq_full;
   assign lsu_acc     = lsu_valid && lsu_ready;
   assign lq_push_dat = '{rd: lsu_rd, data: lsu_data};

   ysyx_22040729_wb_fifo #(
      .DEPTH (LQ_DEPTH),
      .WIDTH ($bits(ld_t))
   ) u_lq (
      .clk      (clk),
      .rst      (rst),
      .push_vld (lq_push_vld),
      .push_dat (lq_push_dat),
      .pop_vld  (lq_pop_vld),
      .head_vld (lq_head_vld),
      .head_dat (lq_head_dat),
      .full     (lq_full)
   );

   // Fixed-priority selection: ALU, then oldest queued load, then a bypassed fresh load.
   always_comb begin
      sel_vld     = 1'b0;
      sel_rd      = '0;
      sel_data    = '0;
      lq_pop_vld  = 1'b0;
      lq_push_vld = 1'b0;
      if (alu_valid) begin
         sel_vld     = 1'b1;
         sel_rd      = alu_rd;
         sel_data    = alu_data;
         lq_push_vld = lsu_acc;
      end else if (lq_head_vld) begin
         sel_vld     = 1'b1;
         sel_rd      = lq_head_dat.rd;
         sel_data    = lq_head_dat.data;
         lq_pop_vld  = 1'b1;
         lq_push_vld = lsu_acc;
      end else if (lsu_acc) begin
         sel_vld     = 1'b1;
         sel_rd      = lsu_rd;
         sel_data    = lsu_data;
      end
   end

   // Next write port value; x0 results are consumed but never enable a write.
   always_comb begin
      rf_wen_d   = sel_vld && (sel_rd != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (sel_vld) begin
         rf_waddr_d = sel_rd;
         rf_wdata_d = sel_data;
      end
   end

   // Scoreboard update: clear on the registered write, then set on issue so set wins.
   always_comb begin
      pend_d = pend_q;
      if (sel_vld)   pend_d[sel_rd] = 1'b0;
      if (iss_valid) pend_d[iss_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Write port and scoreboard registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pend_q     <= '0;
      end else begin
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pend_q     <= pend_d;
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy1    = rst && pend_q[raddr1];
   assign busy2    = rst && pend_q[raddr2];

endmodule
